strobe_latch_bank: RTL and testbench

STROBE_LATCH_BANK -- requirements
Module: strobe_latch_bank

---
 rtl/strobe_latch_bank.sv | 116 +++++++++++
 tb/tb_strobe_latch_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/strobe_latch_bank.sv
// Strobe latch bank: a set of WIDTH-bit channels that capture a shared data
// bus under per-channel strobes (level or rising-edge qualified), with a
// freeze control, a snapshot shadow bank, sticky changed flags and a
// registered one-cycle readback port into the shadow bank.
module strobe_latch_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          D,
  input  logic [CHANNELS-1:0]       ST,
  input  logic                      MODE,
  input  logic                      FREEZE,
  input  logic                      SNAP,
  input  logic                      RD_REQ,
  input  logic [SELW-1:0]           RD_SEL,
  output logic [CHANNELS*WIDTH-1:0] OUT,
  output logic [CHANNELS-1:0]       CHG,
  output logic                      RD_VALID,
  output logic [WIDTH-1:0]          RD_DATA,
  output logic                      RD_ERR
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0][WIDTH-1:0] live;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow;
  logic [CHANNELS-1:0]            prev_st;
  logic [CHANNELS-1:0]            armed;
  logic [CHANNELS-1:0]            edge_seen;
  logic [CHANNELS-1:0]            load;
  logic [CHANNELS-1:0]            chg;
  logic                           sel_in_range;
  logic [IDXW-1:0]                sel_idx;
  logic                           rd_valid;
  logic [WIDTH-1:0]               rd_data;
  logic                           rd_err;

  // armed[k] stays low after reset until the strobe has been seen low, so a
  // strobe held high across reset release never looks like a rising edge.
  assign edge_seen    = ST & ~prev_st & armed;
  assign sel_in_range = 32'(RD_SEL) < 32'(CHANNELS);
  assign sel_idx      = RD_SEL[IDXW-1:0];

  // Decide which channels capture D this cycle; freeze masks every load.
  always_comb begin
    load = '0;
    if (!FREEZE) begin
      load = MODE ? edge_seen : ST;
    end
  end

  // Strobe history runs every cycle, even while frozen, so frozen edges are lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_st <= '0;
      armed   <= ~ST;
    end else begin
      prev_st <= ST;
      armed   <= armed | ~ST;
    end
  end

  // Live bank: each loaded channel takes the shared bus, others hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      live <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          live[k] <= D;
        end
      end
    end
  end

  // Shadow bank copies the pre-load live values when a snapshot is taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow <= '0;
    end else if (SNAP) begin
      shadow <= live;
    end
  end

  // Sticky changed flags: snapshot clears them, a load in the same cycle wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      chg <= '0;
    end else begin
      chg <= (SNAP ? '0 : chg) | load;
    end
  end

  // Readback answers one cycle after each request from the pre-snapshot shadow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= RD_REQ;
      rd_err   <= RD_REQ & ~sel_in_range;
      rd_data  <= (RD_REQ && sel_in_range) ? shadow[sel_idx] : '0;
    end
  end

  assign OUT      = live;
  assign CHG      = chg;
  assign RD_VALID = rd_valid;
  assign RD_DATA  = rd_data;
  assign RD_ERR   = rd_err;

endmodule

// File: tb/tb_strobe_latch_bank.sv
// Self-checking bench for strobe_latch_bank: directed vectors with
// hand-computed snapshots plus a short random phase, all compared against a
// behavioural model of the channel bank, shadow bank and readback port.
module tb_strobe_latch_bank;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 3;

  logic            CLK;
  logic            RST;
  logic [W-1:0]    D;
  logic [CH-1:0]   ST;
  logic            MODE;
  logic            FREEZE;
  logic            SNAP;
  logic            RD_REQ;
  logic [SW-1:0]   RD_SEL;
  logic [CH*W-1:0] OUT;
  logic [CH-1:0]   CHG;
  logic            RD_VALID;
  logic [W-1:0]    RD_DATA;
  logic            RD_ERR;

  strobe_latch_bank #(.WIDTH(W), .CHANNELS(CH), .SELW(SW)) dut (
    .CLK(CLK), .RST(RST), .D(D), .ST(ST), .MODE(MODE), .FREEZE(FREEZE),
    .SNAP(SNAP), .RD_REQ(RD_REQ), .RD_SEL(RD_SEL), .OUT(OUT), .CHG(CHG),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_ERR(RD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model state
  logic [W-1:0]  m_live   [CH] = '{default: '0};
  logic [W-1:0]  m_shadow [CH] = '{default: '0};
  logic [CH-1:0] m_chg     = '0;
  logic [CH-1:0] m_last_st = '0;
  logic          m_valid   = 1'b0;
  logic [W-1:0]  m_data    = '0;
  logic          m_err     = 1'b0;

  int    checks = 0;
  int    errors = 0;
  logic  check_en = 1'b0;
  logic  lit_valid = 1'b0;
  string lit_name = "";
  logic [CH*W+CH+1+W+1-1:0] lit_exp = '0;

  // Model: readback sees the shadow before any snapshot, snapshot sees live
  // values before any load, a load counts as a change.
  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < CH; k++) begin
        m_live[k]   = '0;
        m_shadow[k] = '0;
      end
      m_chg   = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
    end else begin
      m_valid = RD_REQ;
      m_err   = RD_REQ && (int'(RD_SEL) >= CH);
      m_data  = (RD_REQ && int'(RD_SEL) < CH) ? m_shadow[int'(RD_SEL)] : '0;
      if (SNAP) begin
        for (int k = 0; k < CH; k++) m_shadow[k] = m_live[k];
        m_chg = '0;
      end
      for (int k = 0; k < CH; k++) begin
        if (!FREEZE && ST[k] && (!MODE || !m_last_st[k])) begin
          m_live[k] = D;
          m_chg[k]  = 1'b1;
        end
      end
    end
    m_last_st = ST;
  end

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, plus any pending literal snapshot.
  always @(negedge CLK) begin
    if (check_en) begin
      logic [CH*W-1:0] exp_out;
      for (int k = 0; k < CH; k++) exp_out[k*W +: W] = m_live[k];
      checkField("model_out", 64'(OUT), 64'(exp_out));
      checkField("model_chg", 64'(CHG), 64'(m_chg));
      checkField("model_rd_valid", 64'(RD_VALID), 64'(m_valid));
      checkField("model_rd_data", 64'(RD_DATA), 64'(m_data));
      checkField("model_rd_err", 64'(RD_ERR), 64'(m_err));
      if (lit_valid) begin
        checkField(lit_name, 64'({OUT, CHG, RD_VALID, RD_DATA, RD_ERR}), 64'(lit_exp));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [CH-1:0] st, input logic [W-1:0] d,
                               input logic mode, input logic freeze, input logic snap,
                               input logic rdreq, input logic [SW-1:0] sel);
    RST = rst; ST = st; D = d; MODE = mode; FREEZE = freeze;
    SNAP = snap; RD_REQ = rdreq; RD_SEL = sel;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [CH*W-1:0] out, input logic [CH-1:0] chg,
                             input logic v, input logic [W-1:0] data, input logic e);
    lit_name  = name;
    lit_exp   = {out, chg, v, data, e};
    lit_valid = 1'b1;
    @(negedge CLK);
    #1;
    lit_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ST = '0; D = '0; MODE = 1'b0; FREEZE = 1'b0;
    SNAP = 1'b0; RD_REQ = 1'b0; RD_SEL = '0;

    applyStimulus(1, 4'b0000, 8'h00, 0, 0, 0, 0, 3'd0);
    check_en = 1'b1;
    applyStimulus(1, 4'b0000, 8'h00, 0, 0, 0, 0, 3'd0);
    checkOutput("reset", 32'h0, 4'b0000, 0, 8'h00, 0);

    // Level mode tracking on channel 0
    applyStimulus(0, 4'b0001, 8'hA5, 0, 0, 0, 0, 3'd0);
    checkOutput("lvl_a5", 32'h000000A5, 4'b0001, 0, 8'h00, 0);
    applyStimulus(0, 4'b0001, 8'h5A, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 4'b0001, 8'h3C, 0, 0, 0, 0, 3'd0);
    checkOutput("lvl_3c", 32'h0000003C, 4'b0001, 0, 8'h00, 0);

    // Edge mode: held strobe loads once; a frozen edge is lost for good
    applyStimulus(0, 4'b0000, 8'h00, 1, 0, 0, 0, 3'd0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 4'b0100, 8'(i), 1, 0, 0, 0, 3'd0);
    checkOutput("edge_hold", 32'h0001003C, 4'b0101, 0, 8'h00, 0);
    applyStimulus(0, 4'b0000, 8'h00, 1, 0, 0, 0, 3'd0);
    applyStimulus(0, 4'b0100, 8'h77, 1, 1, 0, 0, 3'd0);
    applyStimulus(0, 4'b0100, 8'h88, 1, 0, 0, 0, 3'd0);
    checkOutput("freeze_drop", 32'h0001003C, 4'b0101, 0, 8'h00, 0);

    // Snapshot coincident with a load
    applyStimulus(0, 4'b0000, 8'h00, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 4'b0001, 8'h11, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 4'b0010, 8'h22, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 4'b0010, 8'h99, 0, 0, 1, 0, 3'd0);
    checkOutput("snap_load", 32'h00019911, 4'b0010, 0, 8'h00, 0);

    // Readback: in range, out of range, idle
    applyStimulus(0, 4'b0000, 8'h00, 0, 0, 0, 1, 3'd1);
    checkOutput("rd_ok", 32'h00019911, 4'b0010, 1, 8'h22, 0);
    applyStimulus(0, 4'b0000, 8'h00, 0, 0, 0, 1, 3'd4);
    checkOutput("rd_err", 32'h00019911, 4'b0010, 1, 8'h00, 1);
    applyStimulus(0, 4'b0000, 8'h00, 0, 0, 0, 0, 3'd0);
    checkOutput("rd_idle", 32'h00019911, 4'b0010, 0, 8'h00, 0);

    // Snapshot with read returns old shadow; next read sees the new one
    applyStimulus(0, 4'b0000, 8'h00, 0, 0, 1, 1, 3'd1);
    checkOutput("snap_rd", 32'h00019911, 4'b0000, 1, 8'h22, 0);
    applyStimulus(0, 4'b0000, 8'h00, 0, 0, 0, 1, 3'd1);
    checkOutput("rd_new", 32'h00019911, 4'b0000, 1, 8'h99, 0);
    applyStimulus(0, 4'b0001, 8'hEE, 0, 1, 0, 1, 3'd2);
    checkOutput("freeze_rd", 32'h00019911, 4'b0000, 1, 8'h01, 0);

    // Reset mid-operation, then a strobe held across release
    applyStimulus(0, 4'b1000, 8'hAB, 1, 0, 0, 0, 3'd0);
    applyStimulus(1, 4'b1000, 8'hCD, 1, 0, 0, 1, 3'd1);
    checkOutput("rst_mid", 32'h0, 4'b0000, 0, 8'h00, 0);
    applyStimulus(0, 4'b1000, 8'h55, 1, 0, 0, 0, 3'd0);
    checkOutput("rst_held", 32'h0, 4'b0000, 0, 8'h00, 0);
    applyStimulus(0, 4'b0000, 8'h00, 1, 0, 0, 0, 3'd0);
    applyStimulus(0, 4'b1000, 8'h66, 1, 0, 0, 0, 3'd0);
    checkOutput("rst_rearm", 32'h66000000, 4'b1000, 0, 8'h00, 0);

    // Mixed traffic checked against the model
    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 4'($urandom), 8'($urandom),
                    1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom), 3'($urandom_range(0, 7)));
    end
    applyStimulus(0, 4'b0000, 8'h00, 0, 0, 0, 0, 3'd0);
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
